// File: rtl/gate_ops_pkg.sv
// rtl/gate_ops_pkg.sv - opcode constants and FSM state encoding for the gate-op arbiter
package gate_ops_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational bitwise operation unit with reserved-opcode flag
module logic_unit
    import gate_ops_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         err
);

    // Decode the opcode into a bitwise result; the reserved code yields zero plus err
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_RSVD: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// rtl/gate_op_arbiter.sv - round-robin arbiter feeding a shared bitwise logic unit
module gate_op_arbiter
    import gate_ops_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [3*N_REQ-1:0]       op,
    input  logic [W*N_REQ-1:0]       a,
    input  logic [W*N_REQ-1:0]       b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;
    logic           pick_valid;
    logic [2:0]     op_sel;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   lu_y;
    logic           lu_err;

    // Round-robin pick: scan from ptr+1 and wrap; nearest active requester wins
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the picked requester's opcode and operands for latching
    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                op_sel = op[3*i +: 3];
                a_sel  = a[W*i +: W];
                b_sel  = b[W*i +: W];
            end
        end
    end

    // Next-state logic: grant from IDLE, one EXEC cycle, RESP until consumer accepts
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pick_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Datapath: grant pulse, operand latch, response register; ptr doubles as owner id
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            ptr       <= IDW'(N_REQ - 1);
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt  <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        ptr  <= pick_idx;
                        op_q <= op_sel;
                        a_q  <= a_sel;
                        b_q  <= b_sel;
                    end
                end
                ST_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= ptr;
                    rsp_data  <= lu_y;
                    rsp_err   <= lu_err;
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic_unit #(.W(W)) u_logic_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (lu_y),
        .err (lu_err)
    );

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/gate_op_arbiter.md
GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, fixed range 2..8.
REQ-002 Parameter W, default 8: operand and result width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, N_REQ: per-requester request level.
REQ-006 Port op, input, 3*N_REQ: per-requester opcode; requester i uses bits [3i+2:3i].
REQ-007 Port a, input, W*N_REQ: per-requester operand A; requester i uses bits [W*i+W-1:W*i].
REQ-008 Port b, input, W*N_REQ: per-requester operand B; same slicing as a.
REQ-009 Port gnt, output, N_REQ: registered one-hot grant pulse.
REQ-010 Port rsp_valid, output, 1: response valid.
REQ-011 Port rsp_ready, input, 1: response consumer ready.
REQ-012 Port rsp_id, output, clog2(N_REQ): index of the requester that owns the response.
REQ-013 Port rsp_data, output, W: bitwise result.
REQ-014 Port rsp_err, output, 1: reserved opcode flag.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-017 In IDLE, at any edge with req nonzero: select one requester round-robin, latch its op/a/b, set gnt to that one-hot, record the id, go to EXEC.
REQ-018 Round-robin: search starts at last_granted+1 mod N_REQ and wraps; the pointer updates to the granted index at the grant edge.
REQ-019 In IDLE with req all-zero: stay in IDLE, gnt=0, pointer unchanged.
REQ-020 gnt SHALL be high for exactly one cycle (the EXEC cycle) and zero in every other state.
REQ-021 Requesters hold op/a/b valid while req is high; a req still high after its gnt pulse counts as a new request.
REQ-022 In EXEC, at the next edge: register the logic result into rsp_data, set rsp_valid=1, go to RESP.
REQ-023 Opcode map, per bit: 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
REQ-024 Opcode 7: rsp_data=0 and rsp_err=1; all other opcodes give rsp_err=0.
REQ-025 In RESP: hold rsp_valid, rsp_id, rsp_data and rsp_err stable until the edge with rsp_ready=1, then clear rsp_valid and return to IDLE.
REQ-026 Latency: rsp_valid rises 2 edges after the sampling edge; minimum of 3 cycles between consecutive grants when rsp_ready is held high.
REQ-027 New requests arriving during EXEC or RESP are not sampled until the module is back in IDLE; no request is lost while its req stays high.
REQ-028 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-029 With rst_n low, asynchronously: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, pointer=N_REQ-1 (requester 0 has highest priority first).
REQ-030 Reset during EXEC or RESP SHALL drop the in-flight operation; no response is issued after reset is released.

Structure
REQ-031 Package gate_ops_pkg SHALL hold the opcode constants OP_AND..OP_XNOR and OP_RSVD, plus the FSM state encoding.
REQ-032 Sub-module logic_unit SHALL be purely combinational: inputs op, a, b (W bits); outputs y and err; the arbiter instantiates it once.

Verification
REQ-033 Reset, then req=4'b0001, op0=0, a0=8'hF0, b0=8'h3C, rsp_ready=1 -> gnt=0001 for one cycle; rsp_valid 2 edges after sampling with rsp_id=0, rsp_data=8'h30.
REQ-034 req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart.
REQ-035 Sweep op 0..7 with a=8'hA5, b=8'h0F -> rsp_data 05, AF, 5A, FA, 50, AA, 55, 00; rsp_err=1 only for op 7.
REQ-036 rsp_ready=0 for 5 cycles in RESP while req2 is high -> rsp fields stable, gnt stays 0; req2 is granted on the IDLE edge after the handshake.
REQ-037 rst_n pulsed low during EXEC -> outputs cleared immediately; no rsp_valid after release; the next grant goes to the lowest active index.
REQ-038 Only req3 high, then req1 high -> pointer wraps from 3, so requester 1 is granted before any re-grant of requester 3.
